// File: rtl/nios2_debug_jtag_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG scan master.
// Holds the scan FSM state encoding, the debug-slave IR encodings and the default DR length.
package nios2_debug_jtag_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    E1DR,
    RTI,
    RSP
  } jtag_state_e;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACE     = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  localparam int DR_WIDTH_DEFAULT = 38;

endpackage

// File: rtl/nios2_debug_tck_gen.sv
// Test-clock generator: tck toggles every TCK_HALF clk cycles while run is high, parked low otherwise.
// tck_rise/tck_fall are high in the clk cycle whose closing edge makes tck rise/fall.
module nios2_debug_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int CW = $clog2(TCK_HALF + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(TCK_HALF - 1);

  logic [CW-1:0] half_cnt;
  logic          half_done;

  assign half_done = run && (half_cnt == HALF_LAST);
  assign tck_rise  = half_done && !tck;
  assign tck_fall  = half_done && tck;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      half_cnt <= '0;
      tck      <= 1'b0;
    end else if (!run) begin
      half_cnt <= '0;
      tck      <= 1'b0;
    end else if (half_done) begin
      half_cnt <= '0;
      tck      <= ~tck;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nios2_debug_jtag_scan_master.sv
// Initiator end of the Nios II debug-slave virtual JTAG link: one (IR, DR) scan per command,
// walking UIR -> CDR -> SDR -> E1DR -> RTI on tck falls and returning the captured DR word.
module nios2_debug_jtag_scan_master
  import nios2_debug_jtag_pkg::*;
#(
  parameter int IR_WIDTH   = 2,
  parameter int DR_WIDTH   = DR_WIDTH_DEFAULT,
  parameter int TCK_HALF   = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_e1dr,
  output logic                jtag_state_rti
);

  localparam int BW = $clog2(DR_WIDTH + 1);
  localparam int RW = $clog2(RTI_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);
  localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);

  jtag_state_e         state;
  jtag_state_e         state_next;
  logic                run;
  logic                tck_rise;
  logic                tck_fall;
  logic                accept;
  logic                rsp_load;
  logic [DR_WIDTH-1:0] shift_q;
  logic [DR_WIDTH-1:0] capture_q;
  logic [BW-1:0]       bit_cnt;
  logic [RW-1:0]       rti_cnt;

  // tck only runs while a scan is in flight; it is parked low in IDLE and RSP.
  assign run = (state != IDLE) && (state != RSP);

  nios2_debug_tck_gen #(
    .TCK_HALF (TCK_HALF)
  ) u_tck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .tck      (tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Both ports are valid/ready: a transfer happens on a clk edge where valid and ready are
  // both high; valid, once raised, holds its payload stable until that edge.
  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    rsp_load       = 1'b0;
    cmd_ready      = 1'b0;
    vs_uir         = 1'b0;
    vs_cdr         = 1'b0;
    vs_sdr         = 1'b0;
    vs_e1dr        = 1'b0;
    jtag_state_rti = 1'b0;
    tdi            = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready      = 1'b1;
        jtag_state_rti = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = UIR;
        end
      end
      UIR: begin
        vs_uir = 1'b1;
        if (tck_fall) state_next = CDR;
      end
      CDR: begin
        vs_cdr = 1'b1;
        if (tck_fall) state_next = SDR;
      end
      SDR: begin
        vs_sdr = 1'b1;
        tdi    = shift_q[0];
        if (tck_fall && (bit_cnt == BIT_LAST)) state_next = E1DR;
      end
      E1DR: begin
        vs_e1dr = 1'b1;
        if (tck_fall) state_next = RTI;
      end
      RTI: begin
        jtag_state_rti = 1'b1;
        if (tck_fall && (rti_cnt == RTI_LAST)) begin
          rsp_load   = 1'b1;
          state_next = RSP;
        end
      end
      RSP: begin
        jtag_state_rti = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_in     <= '0;
      shift_q   <= '0;
      capture_q <= '0;
      bit_cnt   <= '0;
      rti_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_dr    <= '0;
    end else begin
      if (accept) begin
        ir_in   <= cmd_ir;
        shift_q <= cmd_dr;
        bit_cnt <= '0;
        rti_cnt <= '0;
      end
      // Sample tdo as tck rises; the first captured bit ends up at [0] after DR_WIDTH rises.
      if ((state == SDR) && tck_rise) begin
        capture_q <= {tdo, capture_q[DR_WIDTH-1:1]};
      end
      if ((state == SDR) && tck_fall) begin
        shift_q <= {1'b0, shift_q[DR_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if ((state == RTI) && tck_fall) begin
        rti_cnt <= rti_cnt + 1'b1;
      end
      if (rsp_load) begin
        rsp_valid <= 1'b1;
        rsp_dr    <= capture_q;
      end else if ((state == RSP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios2_debug_jtag_scan_master.sv
// Directed bench for the virtual-JTAG scan master: loopback and slave-model scans, strobe
// ordering/alignment, mid-scan reset, back-to-back commands and a TCK_HALF=1 instance.
module tb_nios2_debug_jtag_scan_master;
  import nios2_debug_jtag_pkg::*;

  localparam int IW = 2;
  localparam int DW = 38;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // primary instance, TCK_HALF = 2
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [IW-1:0] cmd_ir = '0;
  logic [DW-1:0] cmd_dr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_dr;
  logic          tck, tdi, tdo;
  logic [IW-1:0] ir_in;
  logic          vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti;

  // fast instance, TCK_HALF = 1, tdo looped back
  logic          cmd_valid_b = 1'b0;
  logic          cmd_ready_b;
  logic [IW-1:0] cmd_ir_b = '0;
  logic [DW-1:0] cmd_dr_b = '0;
  logic          rsp_valid_b;
  logic          rsp_ready_b = 1'b0;
  logic [DW-1:0] rsp_dr_b;
  logic          tck_b, tdi_b;
  logic [IW-1:0] ir_in_b;
  logic          vs_uir_b, vs_cdr_b, vs_sdr_b, vs_e1dr_b, rti_b;

  logic          loop_mode = 1'b1;
  logic          slave_load = 1'b0;
  logic [DW-1:0] slave_init = '0;
  logic [DW-1:0] slave = '0;
  assign tdo = loop_mode ? tdi : slave[0];

  nios2_debug_jtag_scan_master #(.IR_WIDTH(IW), .DR_WIDTH(DW), .TCK_HALF(2), .RTI_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dr(rsp_dr), .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .vs_uir(vs_uir),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_e1dr(vs_e1dr), .jtag_state_rti(jtag_state_rti)
  );

  nios2_debug_jtag_scan_master #(.IR_WIDTH(IW), .DR_WIDTH(DW), .TCK_HALF(1), .RTI_CYCLES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_ir(cmd_ir_b), .cmd_dr(cmd_dr_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_dr(rsp_dr_b), .tck(tck_b), .tdi(tdi_b), .tdo(tdi_b), .ir_in(ir_in_b), .vs_uir(vs_uir_b),
    .vs_cdr(vs_cdr_b), .vs_sdr(vs_sdr_b), .vs_e1dr(vs_e1dr_b), .jtag_state_rti(rti_b)
  );

  // 38-bit slave shift register: presents bit 0 on tdo, shifts tdi in at each tck rise in shift-DR
  always @(posedge tck or posedge slave_load) begin
    if (slave_load) slave <= slave_init;
    else if (vs_sdr) slave <= {tdi, slave[DW-1:1]};
  end

  // scoreboard counters and monitors
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q[$];

  int sdr_rises = 0;
  always @(posedge tck) if (vs_sdr) sdr_rises++;

  int seq_q[$];
  int overlap = 0;
  int misalign = 0;
  int tdi_sdr_hi = 0;
  logic [4:0] p_vec = 5'b00001;
  logic p_tck = 1'b0;
  logic p_ready = 1'b1;
  always @(negedge clk) begin
    if (reset_n) begin
      if (vs_uir && !p_vec[4]) seq_q.push_back(1);
      if (vs_cdr && !p_vec[3]) seq_q.push_back(2);
      if (vs_sdr && !p_vec[2]) seq_q.push_back(3);
      if (vs_e1dr && !p_vec[1]) seq_q.push_back(4);
      if ((int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_e1dr)) > 1) overlap++;
      if (({vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti} != p_vec) && !p_ready && !(p_tck && !tck))
        misalign++;
      if (vs_sdr && tdi) tdi_sdr_hi++;
    end
    p_vec   = {vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti};
    p_tck   = tck;
    p_ready = cmd_ready;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_tck", tck, 1'b0);
    check("rst_tdi", tdi, 1'b0);
    check("rst_ir_in", ir_in, '0);
    check("rst_strobes", {vs_uir, vs_cdr, vs_sdr, vs_e1dr}, 4'b0000);
    check("rst_rti", jtag_state_rti, 1'b1);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_dr", rsp_dr, '0);
  endtask

  // present a command and return just after the accepting edge
  task automatic start_cmd(input logic [IW-1:0] ir, input logic [DW-1:0] dr, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // count cycles from the accepting edge (=1) until rsp_valid, watching ir_in
  task automatic wait_rsp(input logic [IW-1:0] ir, output int lat);
    int ir_bad = 0;
    lat = 1;
    while (!rsp_valid && lat < 400) begin
      if (ir_in !== ir) ir_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (ir_in !== ir) ir_bad++;
    check("rsp_timeout", rsp_valid, 1'b1);
    check("ir_in_stable", ir_bad, 0);
  endtask

  task automatic take_rsp();
    check("rsp_dr", rsp_dr, exp_q.pop_front());
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 1'b0);
    check("cmd_ready_after_hs", cmd_ready, 1'b1);
  endtask

  initial begin
    int lat;
    int base;
    int sbase;
    int bad;
    logic [DW-1:0] dr_a;
    logic [DW-1:0] dr_b;

    // 1: reset, then 50 quiet idle cycles
    repeat (5) @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (tck || vs_uir || vs_cdr || vs_sdr || vs_e1dr || !jtag_state_rti || !cmd_ready || rsp_valid) bad++;
    end
    check("idle_quiet", bad, 0);

    // 2 + 4: loopback scan with strobe ordering
    loop_mode = 1'b1;
    base = sdr_rises;
    sbase = seq_q.size();
    dr_a = 38'h2A_5A5A_5A5A;
    exp_q.push_back(dr_a);
    start_cmd(IR_BREAK, dr_a, 1'b0);
    check("uir_after_accept", vs_uir, 1'b1);
    wait_rsp(IR_BREAK, lat);
    check("latency_half2", lat, 173);
    check("sdr_rises", sdr_rises - base, 38);
    check("seq_len", seq_q.size() - sbase, 4);
    for (int i = 0; i < 4; i++)
      check("seq_order", (seq_q.size() > sbase + i) ? seq_q[sbase + i] : 0, i + 1);
    check("rti_in_rsp_tck", tck, 1'b0);
    take_rsp();

    // 3: slave model drives tdo, tdi must stay low in shift-DR
    loop_mode = 1'b0;
    slave_init = 38'h3F_0000_0001;
    slave_load = 1'b1;
    #1;
    slave_load = 1'b0;
    base = tdi_sdr_hi;
    exp_q.push_back(38'h3F_0000_0001);
    start_cmd(IR_OCIMEM, '0, 1'b0);
    wait_rsp(IR_OCIMEM, lat);
    check("tdi_low_in_sdr", tdi_sdr_hi - base, 0);
    check("slave_after_scan", slave, '0);
    take_rsp();
    loop_mode = 1'b1;

    // 5: reset during shift-DR bit 17, then a clean scan
    base = sdr_rises;
    start_cmd(IR_TRACE, 38'h3F_FFFF_FFFF, 1'b0);
    lat = 0;
    while ((sdr_rises - base) < 17 && lat < 400) begin
      @(posedge clk);
      lat++;
    end
    check("reach_bit17", sdr_rises - base, 17);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (rsp_valid || !cmd_ready) bad++;
    end
    check("no_rsp_after_abort", bad, 0);
    exp_q.push_back(38'h15_A5A5_C3C3);
    start_cmd(IR_TRACE, 38'h15_A5A5_C3C3, 1'b0);
    wait_rsp(IR_TRACE, lat);
    check("latency_after_abort", lat, 173);
    take_rsp();

    // 6: back-to-back with cmd_valid held, response stalled 10 cycles
    dr_a = 38'h01_2345_6789;
    dr_b = 38'h3E_DCBA_9876;
    exp_q.push_back(dr_a);
    exp_q.push_back(dr_b);
    start_cmd(IR_BREAK, dr_a, 1'b1);
    cmd_ir = IR_TRACECTRL;
    cmd_dr = dr_b;
    wait_rsp(IR_BREAK, lat);
    check("latency_b2b_first", lat, 173);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", rsp_valid, 1'b1);
      check("hold_rsp_dr", rsp_dr, dr_a);
      check("hold_no_start", {cmd_ready, vs_uir}, 2'b00);
    end
    check("b2b_rsp_dr", rsp_dr, exp_q.pop_front());
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("b2b_idle_after_hs", cmd_ready, 1'b1);
    check("b2b_rsp_valid_drop", rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("b2b_second_start", {cmd_ready, vs_uir}, 2'b01);
    wait_rsp(IR_TRACECTRL, lat);
    check("latency_b2b_second", lat, 173);
    take_rsp();

    check("strobe_overlap", overlap, 0);
    check("strobe_align", misalign, 0);

    // TCK_HALF = 1 instance latency
    @(negedge clk);
    cmd_ir_b = IR_TRACECTRL;
    cmd_dr_b = 38'h0F_1234_5678;
    cmd_valid_b = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_b = 1'b0;
    lat = 1;
    while (!rsp_valid_b && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency_half1", lat, 87);
    check("rsp_dr_half1", rsp_dr_b, 38'h0F_1234_5678);
    check("ir_in_half1", ir_in_b, IR_TRACECTRL);
    @(negedge clk);
    rsp_ready_b = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_b = 1'b0;
    check("half1_idle", {cmd_ready_b, rsp_valid_b}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
